// File: rtl/umtrx_eth_pkt_gate_pkg.sv
// Shared framing, control-register and write-FSM definitions for the Ethernet packet gate.
package umtrx_eth_pkt_gate_pkg;

  localparam int unsigned SOF_BIT = 32;
  localparam int unsigned EOF_BIT = 33;
  localparam int unsigned OCC_MSB = 35;
  localparam int unsigned OCC_LSB = 34;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/umtrx_eth_pkt_gate_if.sv
// Framed 36-bit stream pair: MAC-side input and router-side output of the packet gate.
interface umtrx_eth_pkt_gate_if;
  logic [35:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/umtrx_pkt_gate_ram.sv
// Simple dual-port 36 x 2**SIZE buffer RAM: synchronous write, synchronous read, 1-cycle latency.
module umtrx_pkt_gate_ram #(
  parameter int unsigned SIZE = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [SIZE-1:0] waddr,
  input  logic [35:0]     wdata,
  input  logic            re,
  input  logic [SIZE-1:0] raddr,
  output logic [35:0]     rdata
);

  logic [35:0] mem [2**SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/umtrx_eth_pkt_gate.sv
// Store-and-forward gate: forwards only complete packets, drops malformed/oversize ones whole.
// Optional statistics counters enabled by defining UMTRX_ETH_PKT_GATE_STATS_EN.
module umtrx_eth_pkt_gate
  import umtrx_eth_pkt_gate_pkg::*;
#(
  parameter int unsigned SIZE = 9,
  parameter logic [7:0]  BASE = 8'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  umtrx_eth_pkt_gate_if.slave  strm,
  output logic [SIZE:0]        occupied,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count
);

  typedef logic [SIZE:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(2**SIZE);

  wr_state_e   state, state_nxt;
  ptr_t        wr, wr_nxt, commit, commit_nxt, rd, base, inflight;
  logic        ctrl_en, ram_we, fetch, pre_v, start, sof, eof;
  logic [1:0]  drop_inc;
  logic [35:0] ram_rdata;

  assign strm.in_ready = 1'b1;
  assign sof = strm.in_data[SOF_BIT];
  assign eof = strm.in_data[EOF_BIT];

  // Words sitting in the RAM read register or the output register still hold
  // buffer space, so they count towards occupancy and fullness.
  assign inflight = ptr_t'(pre_v) + ptr_t'(strm.out_valid);
  assign occupied = wr - rd + inflight;
  assign fetch    = (rd != commit) && (!strm.out_valid || strm.out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              ctrl_en <= 1'b0;
    else if (clear)                         ctrl_en <= 1'b0;
    else if (set_stb && set_addr == BASE)   ctrl_en <= set_data[CTRL_EN_BIT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  // A truncated packet (SOF while writing) rewinds to commit and the SOF word
  // is then handled as a fresh start from that rewound base.
  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr;
    commit_nxt = commit;
    ram_we     = 1'b0;
    base       = wr;
    drop_inc   = 2'd0;
    start      = 1'b0;
    if (strm.in_valid) begin
      case (state)
        IDLE: start = 1'b1;
        WRITE: begin
          if (sof) begin
            base     = commit;
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if (occupied == DEPTH) begin
            wr_nxt    = commit;
            drop_inc  = 2'd1;
            state_nxt = eof ? IDLE : DROP;
          end else begin
            ram_we = 1'b1;
            wr_nxt = wr + 1'b1;
            if (eof) begin
              commit_nxt = wr + 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
        DROP:    if (eof) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (start) begin
        if (sof && ctrl_en && (base - rd + inflight) != DEPTH) begin
          ram_we    = 1'b1;
          wr_nxt    = base + 1'b1;
          state_nxt = eof ? IDLE : WRITE;
          if (eof) commit_nxt = base + 1'b1;
        end else begin
          wr_nxt    = base;
          drop_inc  = drop_inc + 2'd1;
          state_nxt = eof ? IDLE : DROP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= '0; commit <= '0; rd <= '0; pre_v <= 1'b0;
      strm.out_valid <= 1'b0; strm.out_data <= '0;
    end else if (clear) begin
      wr <= '0; commit <= '0; rd <= '0; pre_v <= 1'b0;
      strm.out_valid <= 1'b0; strm.out_data <= '0;
    end else begin
      wr     <= wr_nxt;
      commit <= commit_nxt;
      if (fetch) rd <= rd + 1'b1;
      pre_v <= fetch || (pre_v && strm.out_valid && !strm.out_ready);
      if (!strm.out_valid || strm.out_ready) begin
        strm.out_valid <= pre_v;
        if (pre_v) strm.out_data <= ram_rdata;
      end
    end
  end

  umtrx_pkt_gate_ram #(.SIZE(SIZE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (base[SIZE-1:0]),
    .wdata (strm.in_data),
    .re    (fetch),
    .raddr (rd[SIZE-1:0]),
    .rdata (ram_rdata)
  );

`ifdef UMTRX_ETH_PKT_GATE_STATS_EN
  logic        clr_stats;
  logic [15:0] pkt_cnt, drop_cnt;
  logic        unused_cfg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_stats <= 1'b0; pkt_cnt <= '0; drop_cnt <= '0;
    end else if (clear) begin
      clr_stats <= 1'b0; pkt_cnt <= '0; drop_cnt <= '0;
    end else begin
      clr_stats <= set_stb && (set_addr == BASE) && set_data[CTRL_CLR_BIT];
      if (clr_stats) begin
        pkt_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        pkt_cnt  <= sat_add16(pkt_cnt,
                      {1'b0, strm.out_valid && strm.out_ready && strm.out_data[EOF_BIT]});
        drop_cnt <= sat_add16(drop_cnt, drop_inc);
      end
    end
  end

  assign pkt_count  = pkt_cnt;
  assign drop_count = drop_cnt;
  assign unused_cfg = ^set_data[31:2];
`else
  logic unused_cfg;
  assign pkt_count  = '0;
  assign drop_count = '0;
  assign unused_cfg = ^{set_data[31:1], drop_inc};
`endif

endmodule

// File: tb/tb_umtrx_eth_pkt_gate.sv
// Scoreboard bench for umtrx_eth_pkt_gate: packet-level reference model plus a SIZE=4 overflow instance.
module tb_umtrx_eth_pkt_gate;
  import umtrx_eth_pkt_gate_pkg::*;

  localparam int unsigned DEPTH = 512;
`ifdef UMTRX_ETH_PKT_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [9:0]  occupied;
  logic [4:0]  occupied4;
  logic [15:0] pkt_count, drop_count, pkt_count4, drop_count4;

  umtrx_eth_pkt_gate_if bus ();
  umtrx_eth_pkt_gate_if bus4 ();

  umtrx_eth_pkt_gate #(.SIZE(9), .BASE(8'd0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .strm(bus), .occupied(occupied), .pkt_count(pkt_count),
    .drop_count(drop_count));

  umtrx_eth_pkt_gate #(.SIZE(4), .BASE(8'd0)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .strm(bus4), .occupied(occupied4), .pkt_count(pkt_count4),
    .drop_count(drop_count4));

  int unsigned n_cmp = 0, n_bad = 0;
  logic [35:0] exp_q[$], exp4_q[$], cur[$];
  bit          in_pkt = 0, discarding = 0, m_en = 0;
  int unsigned m_pkts = 0, m_drops = 0;
  int unsigned rdy_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int unsigned stat(input int unsigned v);
    return STATS ? ((v > 65535) ? 65535 : v) : 0;
  endfunction

  function automatic logic [35:0] mkw(input bit s, input bit e);
    logic [1:0]  occ;
    logic [31:0] d;
    occ = 2'($urandom_range(0, 3));
    d   = $urandom;
    return {occ, e, s, d};
  endfunction

  // Packet-level reference: a packet is kept only if it starts with SOF while
  // enabled, ends with EOF before any new SOF, and is no longer than DEPTH.
  task automatic model_word(input logic [35:0] w);
    bit s, e;
    s = w[SOF_BIT];
    e = w[EOF_BIT];
    if (in_pkt && s) begin m_drops++; cur.delete(); in_pkt = 0; end
    if (in_pkt) begin
      if (cur.size() == DEPTH) begin
        m_drops++; cur.delete(); in_pkt = 0; discarding = !e;
      end else begin
        cur.push_back(w);
        if (e) begin
          foreach (cur[i]) exp_q.push_back(cur[i]);
          m_pkts++; cur.delete(); in_pkt = 0;
        end
      end
    end else if (discarding) begin
      if (e) discarding = 0;
    end else if (s && m_en) begin
      if (e) begin exp_q.push_back(w); m_pkts++; end
      else begin cur.push_back(w); in_pkt = 1; end
    end else begin
      m_drops++;
      discarding = !e;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b4, input logic [35:0] w);
    if (b4) begin bus4.in_data = w; bus4.in_valid = 1'b1; end
    else begin bus.in_data = w; bus.in_valid = 1'b1; model_word(w); end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned len);
    for (int unsigned i = 0; i < len; i++) send(1'b0, mkw(i == 0, i == len - 1));
  endtask

  task automatic set_ctrl(input logic [31:0] d);
    set_stb = 1'b1; set_addr = 8'd0; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
    m_en = d[0];
    if (d[1]) begin m_pkts = 0; m_drops = 0; end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    rdy_mode = 2;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 5000) begin idle(1); n++; end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic check_counts(input string tag);
    wait_drain();
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(stat(m_pkts)));
    check({tag, "_drop_count"}, 64'(drop_count), 64'(stat(m_drops)));
    check({tag, "_occupied"}, 64'(occupied), 64'(cur.size()));
  endtask

  task automatic model_flush();
    exp_q.delete(); cur.delete();
    in_pkt = 0; discarding = 0; m_en = 0; m_pkts = 0; m_drops = 0;
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out_unexpected: got %h expected no word", bus.out_data);
      end else check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
      if (exp4_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out4_unexpected: got %h expected no word", bus4.out_data);
      end else check("out4_data", 64'(bus4.out_data), 64'(exp4_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [35:0] w;
    int unsigned n;
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    idle(3);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_occupied", 64'(occupied), 64'd0);
    check("rst_counts", 64'({pkt_count, drop_count}), 64'd0);
    reset = 1'b0;
    idle(2);

    // 1: single 4-word packet, first word two cycles after EOF accepted
    set_ctrl(32'd1);
    rdy_mode = 1;
    send_pkt(4);
    check("lat_e0", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("lat_e1", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("lat_e2", 64'(bus.out_valid), 64'd1);
    check_counts("t1");

    // 2: headless tail word then a good 3-word packet
    send(1'b0, mkw(1'b0, 1'b1));
    send_pkt(3);
    check_counts("t2");

    // 3: SIZE=4 instance, second packet overflows behind a committed 10-word packet
    for (int unsigned i = 0; i < 10; i++) begin
      w = mkw(i == 0, i == 9);
      exp4_q.push_back(w);
      send(1'b1, w);
    end
    for (int unsigned i = 0; i < 8; i++) send(1'b1, mkw(i == 0, i == 7));
    idle(3);
    check("t3_occupied", 64'(occupied4), 64'd10);
    check("t3_drop_count", 64'(drop_count4), 64'(stat(1)));
    check("t3_pkt_before", 64'(pkt_count4), 64'd0);
    bus4.out_ready = 1'b1;
    n = 0;
    while ((exp4_q.size() != 0 || bus4.out_valid) && n < 200) begin idle(1); n++; end
    idle(2);
    check("t3_left", 64'(exp4_q.size()), 64'd0);
    check("t3_pkt_count", 64'(pkt_count4), 64'(stat(1)));
    check("t3_occ_end", 64'(occupied4), 64'd0);

    // 4: truncated packet followed by a good one
    send(1'b0, mkw(1'b1, 1'b0));
    send(1'b0, mkw(1'b0, 1'b0));
    send(1'b0, mkw(1'b0, 1'b0));
    send_pkt(3);
    check_counts("t4");

    // 5: disable mid-packet; in-progress packet completes, next one dropped
    send(1'b0, mkw(1'b1, 1'b0));
    set_ctrl(32'd0);
    send(1'b0, mkw(1'b0, 1'b1));
    send_pkt(2);
    set_ctrl(32'd1);
    check_counts("t5");

    // boundary: exactly DEPTH words fits, DEPTH+1 is dropped
    send_pkt(DEPTH);
    send_pkt(DEPTH + 1);
    check_counts("size");

    // randomized framing with occasional enable changes and idle gaps
    rdy_mode = 2;
    for (int unsigned f = 0; f < 150; f++) begin
      int unsigned kind, g;
      g = 0;
      while (exp_q.size() + cur.size() > 400 && g < 5000) begin idle(1); g++; end
      if ($urandom_range(0, 11) == 0) set_ctrl({31'd0, 1'($urandom_range(0, 3) != 0)});
      kind = $urandom_range(0, 9);
      n = (kind < 6) ? $urandom_range(1, 12) : $urandom_range(1, 4);
      if (kind < 6) send_pkt(n);
      else if (kind < 8) for (int unsigned i = 0; i < n; i++) send(1'b0, mkw(1'b0, i == n - 1));
      else for (int unsigned i = 0; i < n; i++) send(1'b0, mkw(i == 0, 1'b0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    check_counts("rand");

    // stats clear pulse
    set_ctrl(32'd3);
    idle(2);
    check("clr_counts", 64'({pkt_count, drop_count}), 64'd0);

    // 6: asynchronous reset mid-packet while output is busy
    set_ctrl(32'd1);
    send_pkt(6);
    n = 0;
    while (!bus.out_valid && n < 20) begin idle(1); n++; end
    send(1'b0, mkw(1'b1, 1'b0));
    send(1'b0, mkw(1'b0, 1'b0));
    reset = 1'b1;
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_occupied", 64'(occupied), 64'd0);
    model_flush();
    idle(2);
    reset = 1'b0;
    idle(1);
    set_ctrl(32'd1);
    send_pkt(3);
    check_counts("t6");

    // synchronous clear mid-packet
    send(1'b0, mkw(1'b1, 1'b0));
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    model_flush();
    check("clear_occupied", 64'(occupied), 64'd0);
    set_ctrl(32'd1);
    send_pkt(5);
    check_counts("clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
